alu_uart_interface: RTL

Sequencer between the UART receiver/transmitter and the combinational `alu`. It collects three received bytes in order: operand A, operand B, then opcode. It drives them onto the ALU inputs, then captures the ALU result and hands it to the UART transmitter as one byte. It holds ALU inputs stable between transactions and discards unsupported opcodes.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_uart_interface.sv | 71 +++++++
 2 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, opcode support check and sequencer state encoding shared with alu
package alu_pkg;
  localparam logic [5:0] OP_ADD = 6'd32;
  localparam logic [5:0] OP_SUB = 6'd34;
  localparam logic [5:0] OP_AND = 6'd36;
  localparam logic [5:0] OP_OR  = 6'd37;
  localparam logic [5:0] OP_XOR = 6'd38;
  localparam logic [5:0] OP_SRA = 6'd3;
  localparam logic [5:0] OP_SRL = 6'd4;
  localparam logic [5:0] OP_NOR = 6'd39;
  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX} state_t;
  function automatic logic is_supported_op(input logic [5:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
  endfunction
endpackage

// File: rtl/alu_uart_interface.sv
// alu_uart_interface: gathers A, B, opcode from the UART receiver, feeds the alu, sends its result back
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_dato_a,
  output logic [NB_DATA-1:0] o_dato_b,
  output logic [NB_OP-1:0]   o_operation,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy
);
  state_t state, state_n;
  logic [NB_DATA-1:0] a_n, b_n, tx_n;
  logic [NB_OP-1:0] op, op_n;
  assign op = i_rx_data[NB_OP-1:0];
  assign o_busy = (state == SEND) || (state == WAIT_TX);
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= WAIT_A;
      o_dato_a    <= '0;
      o_dato_b    <= '0;
      o_operation <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
    end else begin
      state       <= state_n;
      o_dato_a    <= a_n;
      o_dato_b    <= b_n;
      o_operation <= op_n;
      o_tx_data   <= tx_n;
      o_tx_start  <= state == SEND;
    end
  end
  always_comb begin
    state_n = state;
    a_n     = o_dato_a;
    b_n     = o_dato_b;
    op_n    = o_operation;
    tx_n    = o_tx_data;
    case (state)
      WAIT_A: if (i_rx_done) begin
        a_n     = i_rx_data;
        state_n = WAIT_B;
      end
      WAIT_B: if (i_rx_done) begin
        b_n     = i_rx_data;
        state_n = WAIT_OP;
      end
      // unsupported opcodes are dropped without leaving WAIT_OP
      WAIT_OP: if (i_rx_done && is_supported_op(op)) begin
        op_n    = op;
        state_n = SEND;
      end
      SEND: begin
        tx_n    = i_alu_result;
        state_n = WAIT_TX;
      end
      WAIT_TX: state_n = i_tx_done ? WAIT_A : WAIT_TX;
      default: state_n = WAIT_A;
    endcase
  end
endmodule
